credit_fifo_stage: RTL and testbench

//  Parametrised credit-based pipeline stage for the DySER fabric: buffers up to DEPTH words of

---
 rtl/credit_fifo_stage.sv | 110 +++++++++++
 tb/tb_credit_fifo_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/credit_fifo_stage.sv
// Credit-based buffering pipeline stage: a FIFO of DEPTH words that releases data only against
// downstream credit and returns one credit upstream for each word it sends.
module credit_fifo_stage #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DCREDIT_INIT = 1,
    parameter int unsigned FU_MODE      = 0,
    parameter int unsigned ID           = 0,
    localparam int unsigned CW          = $clog2(DEPTH + 1),
    localparam int unsigned DW          = $clog2(DCREDIT_INIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             done,
    input  logic             credit_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             credit_out,
    output logic [CW-1:0]    count,
    output logic [DW-1:0]    dcredit,
    output logic             err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    logic             wr_req_c;
    logic             empty_c;
    logic             full_c;
    logic             send_c;
    logic             pop_c;
    logic             bypass_c;
    logic             push_c;
    logic             overflow_c;
    logic             fu_err_c;
    logic             cr_full_c;
    logic             cr_err_c;
    logic [WIDTH-1:0] send_word_c;
    logic [CW-1:0]    count_nxt_c;
    logic [DW-1:0]    dcredit_nxt_c;

    // Instance tag carries no function.
    logic unused_id;
    assign unused_id = (ID == 0);

    // Send/accept decisions from registered state and this cycle's inputs.
    always_comb begin
        wr_req_c      = valid_in & ((FU_MODE != 0) ? done : 1'b1);
        empty_c       = (count == '0);
        full_c        = (count == CW'(DEPTH));
        send_c        = (!empty_c | wr_req_c) & (dcredit != '0);
        pop_c         = send_c & !empty_c;
        bypass_c      = send_c & empty_c;
        push_c        = wr_req_c & !bypass_c & (!full_c | pop_c);
        overflow_c    = wr_req_c & !bypass_c & full_c & !pop_c;
        fu_err_c      = (FU_MODE != 0) & valid_in & !done;
        cr_full_c     = (dcredit == DW'(DCREDIT_INIT));
        cr_err_c      = credit_in & cr_full_c & !send_c;
        send_word_c   = empty_c ? data_in : mem[rd_ptr];
        count_nxt_c   = count + CW'(push_c) - CW'(pop_c);
        dcredit_nxt_c = dcredit;
        if (credit_in && !send_c && !cr_full_c) begin
            dcredit_nxt_c = dcredit + DW'(1);
        end else if (!credit_in && send_c) begin
            dcredit_nxt_c = dcredit - DW'(1);
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            credit_out <= 1'b0;
            err        <= 1'b0;
            data_out   <= '0;
            count      <= '0;
            dcredit    <= DW'(DCREDIT_INIT);
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            valid_out  <= send_c;
            credit_out <= send_c;
            err        <= overflow_c | fu_err_c | cr_err_c;
            count      <= count_nxt_c;
            dcredit    <= dcredit_nxt_c;
            if (send_c) begin
                data_out <= send_word_c;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    // Storage array needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_credit_fifo_stage.sv
// Bench for credit_fifo_stage: a switch-mode and an FU-mode instance share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_credit_fifo_stage;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DINIT = 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned DW    = $clog2(DINIT + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             valid_in;
    logic             done;
    logic             credit_in;
    logic [WIDTH-1:0] data_in;

    logic             vout [2];
    logic             cout [2];
    logic             err  [2];
    logic [WIDTH-1:0] dout [2];
    logic [CW-1:0]    cnt  [2];
    logic [DW-1:0]    dcr  [2];

    credit_fifo_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DCREDIT_INIT(DINIT), .FU_MODE(0), .ID(0)) u_sw (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .done(done),
        .credit_in(credit_in), .valid_out(vout[0]), .data_out(dout[0]), .credit_out(cout[0]),
        .count(cnt[0]), .dcredit(dcr[0]), .err(err[0]));

    credit_fifo_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DCREDIT_INIT(DINIT), .FU_MODE(1), .ID(1)) u_fu (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .done(done),
        .credit_in(credit_in), .valid_out(vout[1]), .data_out(dout[1]), .credit_out(cout[1]),
        .count(cnt[1]), .dcredit(dcr[1]), .err(err[1]));

    logic [WIDTH-1:0] mq [2][$];
    int               mdcr  [2];
    bit               mvout [2];
    bit               merr  [2];
    logic [WIDTH-1:0] mdout [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one clock of the stage, instance k (k==1 is the FU-mode stage).
    task automatic model_step(input int k);
        bit wr, snd, byp, e;
        if (rst) begin
            mq[k].delete();
            mdcr[k]  = DINIT;
            mvout[k] = 1'b0;
            merr[k]  = 1'b0;
            mdout[k] = '0;
            return;
        end
        wr  = valid_in && (k == 0 || done);
        snd = (mdcr[k] > 0) && (mq[k].size() > 0 || wr);
        byp = 1'b0;
        e   = 1'b0;
        if (snd) begin
            if (mq[k].size() > 0) mdout[k] = mq[k].pop_front();
            else begin
                mdout[k] = data_in;
                byp      = 1'b1;
            end
        end
        if (wr && !byp) begin
            if (mq[k].size() < DEPTH) mq[k].push_back(data_in);
            else e = 1'b1;
        end
        if (k == 1 && valid_in && !done) e = 1'b1;
        if (credit_in) begin
            if (mdcr[k] == DINIT && !snd) e = 1'b1;
            else mdcr[k]++;
        end
        if (snd) mdcr[k]--;
        mvout[k] = snd;
        merr[k]  = e;
    endtask

    task automatic cycle(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit dn, input bit c);
        rst       = r;
        valid_in  = v;
        data_in   = d;
        done      = dn;
        credit_in = c;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("valid_out%0d", k),  64'(vout[k]), 64'(mvout[k]));
            check($sformatf("credit_out%0d", k), 64'(cout[k]), 64'(mvout[k]));
            check($sformatf("err%0d", k),        64'(err[k]),  64'(merr[k]));
            check($sformatf("data_out%0d", k),   64'(dout[k]), 64'(mdout[k]));
            check($sformatf("count%0d", k),      64'(cnt[k]),  64'(mq[k].size()));
            check($sformatf("dcredit%0d", k),    64'(dcr[k]),  64'(mdcr[k]));
        end
    endtask

    initial begin
        cycle(1, 0, '0, 1, 0);
        cycle(1, 0, '0, 1, 0);
        check("rst_count", 64'(cnt[0]), 64'd0);
        check("rst_dcredit", 64'(dcr[0]), 64'(DINIT));

        // Bypass latency on an empty stage holding one credit.
        cycle(0, 1, 32'h11, 1, 0);
        check("t1_vout", 64'(vout[0]), 64'd1);
        check("t1_cout", 64'(cout[0]), 64'd1);
        check("t1_dout", 64'(dout[0]), 64'h11);
        check("t1_dcr", 64'(dcr[0]), 64'd0);

        // Fill without credit, overflow, then release the head.
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'hA0 + 32'(i), 1, 0);
        check("t2_full", 64'(cnt[0]), 64'd4);
        check("t2_novout", 64'(vout[0]), 64'd0);
        cycle(0, 1, 32'hE0, 1, 0);
        check("t2_ovf_err", 64'(err[0]), 64'd1);
        check("t2_ovf_cnt", 64'(cnt[0]), 64'd4);
        cycle(0, 0, '0, 1, 1);
        cycle(0, 0, '0, 1, 0);
        check("t2_pop_vout", 64'(vout[0]), 64'd1);
        check("t2_pop_dout", 64'(dout[0]), 64'hA0);
        check("t2_pop_cnt", 64'(cnt[0]), 64'd3);

        // Reset mid-operation, then a surplus credit.
        cycle(1, 0, '0, 1, 0);
        check("t6_cnt", 64'(cnt[0]), 64'd0);
        check("t6_dcr", 64'(dcr[0]), 64'(DINIT));
        check("t6_dout", 64'(dout[0]), 64'd0);
        cycle(0, 0, '0, 1, 1);
        check("t5_err", 64'(err[0]), 64'd1);
        check("t5_novout", 64'(vout[0]), 64'd0);
        check("t5_dcr", 64'(dcr[0]), 64'(DINIT));

        // Streaming with a returning credit every cycle.
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 32'(i), 1, 1);
            check("t3_vout", 64'(vout[0]), 64'd1);
            check("t3_dout", 64'(dout[0]), 64'(i));
        end
        cycle(0, 0, '0, 1, 0);
        check("t3_dcr", 64'(dcr[0]), 64'd1);
        check("t3_cnt", 64'(cnt[0]), 64'd0);

        // FU stage: valid without done is an error, with done it is sent.
        cycle(0, 1, 32'h22, 0, 0);
        check("t4_err", 64'(err[1]), 64'd1);
        check("t4_cnt", 64'(cnt[1]), 64'd0);
        cycle(0, 1, 32'h33, 1, 0);
        check("t4_vout", 64'(vout[1]), 64'd1);
        check("t4_dout", 64'(dout[1]), 64'h33);

        // Random traffic with phases of scarce and plentiful credit.
        for (int i = 0; i < 4000; i++) begin
            int cp;
            cp = ((i / 250) % 2 == 0) ? 25 : 70;
            cycle($urandom_range(0, 149) == 0,
                  $urandom_range(0, 99) < 60,
                  $urandom,
                  $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < cp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
